rvfi_wrap_fifo: RTL and testbench

// - Reverse of the RVFI flatten path: takes NRET lanes of flat per-lane RVFI vectors from the core's retire stage.
// - Repacks each valid lane into an ariane_rvfi_pkg::rvfi_lane_t struct.
// - Compacts lanes in order into a ring buffer and streams one retired instruction per cycle to the tracer/checker with valid/ready.
// - Checks rvfi order continuity and reports overflow, since RVFI cannot be stalled.

---
 rtl/ariane_rvfi_pkg.sv | 35 +++
 rtl/rvfi_lane_pack.sv | 57 +++++
 rtl/rvfi_wrap_fifo.sv | 165 ++++++++++++++++
 tb/tb_rvfi_wrap_fifo.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/ariane_rvfi_pkg.sv
// RVFI types shared by the retire-side tracer plumbing.
// rvfi_lane_t is the single-lane view of one retired instruction.
package ariane_rvfi_pkg;

   localparam int unsigned NRET = 2;
   localparam int unsigned XLEN = 64;
   localparam int unsigned ILEN = 32;
   localparam int unsigned XB   = XLEN / 8;

   typedef struct packed {
      logic            valid;
      logic [63:0]     order;
      logic [ILEN-1:0] insn;
      logic            trap;
      logic            halt;
      logic            intr;
      logic [XLEN-1:0] cause;
      logic [1:0]      mode;
      logic [1:0]      ixl;
      logic [4:0]      rs1_addr;
      logic [4:0]      rs2_addr;
      logic [XLEN-1:0] rs1_rdata;
      logic [XLEN-1:0] rs2_rdata;
      logic [4:0]      rd_addr;
      logic [XLEN-1:0] rd_wdata;
      logic [XLEN-1:0] pc_rdata;
      logic [XLEN-1:0] pc_wdata;
      logic [XLEN-1:0] mem_addr;
      logic [XB-1:0]   mem_rmask;
      logic [XB-1:0]   mem_wmask;
      logic [XLEN-1:0] mem_rdata;
      logic [XLEN-1:0] mem_wdata;
   } rvfi_lane_t;

endpackage

// File: rtl/rvfi_lane_pack.sv
// Packs one lane's worth of flat RVFI signals into an rvfi_lane_t.
// The top hands over lane-sized slices; this stays purely combinational.
module rvfi_lane_pack
   import ariane_rvfi_pkg::*;
(
   input  logic            valid_i,
   input  logic            trap_i,
   input  logic            halt_i,
   input  logic            intr_i,
   input  logic [63:0]     order_i,
   input  logic [ILEN-1:0] insn_i,
   input  logic [XLEN-1:0] cause_i,
   input  logic [1:0]      mode_i,
   input  logic [1:0]      ixl_i,
   input  logic [4:0]      rs1_addr_i,
   input  logic [4:0]      rs2_addr_i,
   input  logic [XLEN-1:0] rs1_rdata_i,
   input  logic [XLEN-1:0] rs2_rdata_i,
   input  logic [4:0]      rd_addr_i,
   input  logic [XLEN-1:0] rd_wdata_i,
   input  logic [XLEN-1:0] pc_rdata_i,
   input  logic [XLEN-1:0] pc_wdata_i,
   input  logic [XLEN-1:0] mem_addr_i,
   input  logic [XB-1:0]   mem_rmask_i,
   input  logic [XB-1:0]   mem_wmask_i,
   input  logic [XLEN-1:0] mem_rdata_i,
   input  logic [XLEN-1:0] mem_wdata_i,
   output rvfi_lane_t      lane_o
);

   always_comb begin
      lane_o           = '0;
      lane_o.valid     = valid_i;
      lane_o.order     = order_i;
      lane_o.insn      = insn_i;
      lane_o.trap      = trap_i;
      lane_o.halt      = halt_i;
      lane_o.intr      = intr_i;
      lane_o.cause     = cause_i;
      lane_o.mode      = mode_i;
      lane_o.ixl       = ixl_i;
      lane_o.rs1_addr  = rs1_addr_i;
      lane_o.rs2_addr  = rs2_addr_i;
      lane_o.rs1_rdata = rs1_rdata_i;
      lane_o.rs2_rdata = rs2_rdata_i;
      lane_o.rd_addr   = rd_addr_i;
      lane_o.rd_wdata  = rd_wdata_i;
      lane_o.pc_rdata  = pc_rdata_i;
      lane_o.pc_wdata  = pc_wdata_i;
      lane_o.mem_addr  = mem_addr_i;
      lane_o.mem_rmask = mem_rmask_i;
      lane_o.mem_wmask = mem_wmask_i;
      lane_o.mem_rdata = mem_rdata_i;
      lane_o.mem_wdata = mem_wdata_i;
   end

endmodule

// File: rtl/rvfi_wrap_fifo.sv
// Compacts NRET retire lanes into a ring buffer and streams one
// retired instruction per cycle, with order and overflow checking.
module rvfi_wrap_fifo
   import ariane_rvfi_pkg::*;
#(
   parameter int unsigned DEPTH      = 8,
   parameter logic [63:0] ORDER_INIT = 64'd0
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       clear_i,
   input  logic [NRET-1:0]            valid_i,
   input  logic [NRET-1:0]            trap_i,
   input  logic [NRET-1:0]            halt_i,
   input  logic [NRET-1:0]            intr_i,
   input  logic [NRET*64-1:0]         order_i,
   input  logic [NRET*ILEN-1:0]       insn_i,
   input  logic [NRET*XLEN-1:0]       cause_i,
   input  logic [NRET*XLEN-1:0]       rs1_rdata_i,
   input  logic [NRET*XLEN-1:0]       rs2_rdata_i,
   input  logic [NRET*XLEN-1:0]       rd_wdata_i,
   input  logic [NRET*XLEN-1:0]       pc_rdata_i,
   input  logic [NRET*XLEN-1:0]       pc_wdata_i,
   input  logic [NRET*XLEN-1:0]       mem_addr_i,
   input  logic [NRET*2-1:0]          mode_i,
   input  logic [NRET*2-1:0]          ixl_i,
   input  logic [NRET*5-1:0]          rs1_addr_i,
   input  logic [NRET*5-1:0]          rs2_addr_i,
   input  logic [NRET*5-1:0]          rd_addr_i,
   input  logic [NRET*XB-1:0]         mem_rmask_i,
   input  logic [NRET*XB-1:0]         mem_wmask_i,
   input  logic [NRET*XLEN-1:0]       mem_rdata_i,
   input  logic [NRET*XLEN-1:0]       mem_wdata_i,
   output logic                       rvfi_valid_o,
   input  logic                       rvfi_ready_i,
   output rvfi_lane_t                 rvfi_lane_o,
   output logic [$clog2(DEPTH+1)-1:0] count_o,
   output logic                       overflow_o,
   output logic                       order_err_o,
   output logic [31:0]                drop_cnt_o
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH+1);

   rvfi_lane_t      lanes [NRET];
   rvfi_lane_t      mem   [DEPTH];
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;
   logic [CW-1:0]   idx   [NRET];
   logic [CW-1:0]   n;
   logic [CW-1:0]   free;
   logic            push;
   logic            drop;
   logic            pop;
   logic            ord_bad;
   logic [63:0]     exp_q;
   logic [63:0]     exp_nxt;
   logic [32:0]     drop_sum;

   for (genvar k = 0; k < NRET; k++) begin : g_lane
      rvfi_lane_pack u_pack (
         .valid_i     (valid_i[k]),
         .trap_i      (trap_i[k]),
         .halt_i      (halt_i[k]),
         .intr_i      (intr_i[k]),
         .order_i     (order_i[k*64 +: 64]),
         .insn_i      (insn_i[k*ILEN +: ILEN]),
         .cause_i     (cause_i[k*XLEN +: XLEN]),
         .mode_i      (mode_i[k*2 +: 2]),
         .ixl_i       (ixl_i[k*2 +: 2]),
         .rs1_addr_i  (rs1_addr_i[k*5 +: 5]),
         .rs2_addr_i  (rs2_addr_i[k*5 +: 5]),
         .rs1_rdata_i (rs1_rdata_i[k*XLEN +: XLEN]),
         .rs2_rdata_i (rs2_rdata_i[k*XLEN +: XLEN]),
         .rd_addr_i   (rd_addr_i[k*5 +: 5]),
         .rd_wdata_i  (rd_wdata_i[k*XLEN +: XLEN]),
         .pc_rdata_i  (pc_rdata_i[k*XLEN +: XLEN]),
         .pc_wdata_i  (pc_wdata_i[k*XLEN +: XLEN]),
         .mem_addr_i  (mem_addr_i[k*XLEN +: XLEN]),
         .mem_rmask_i (mem_rmask_i[k*XB +: XB]),
         .mem_wmask_i (mem_wmask_i[k*XB +: XB]),
         .mem_rdata_i (mem_rdata_i[k*XLEN +: XLEN]),
         .mem_wdata_i (mem_wdata_i[k*XLEN +: XLEN]),
         .lane_o      (lanes[k])
      );
   end

   // Prefix sum gives each valid lane its slot offset from wr_ptr.
   always_comb begin
      n = '0;
      for (int k = 0; k < NRET; k++) begin
         idx[k] = n;
         if (valid_i[k]) n = n + CW'(1);
      end
   end

   // Pop is not credited: free space is judged on the cycle-start count.
   assign free  = CW'(DEPTH) - count_o;
   assign push  = !clear_i && (n != '0) && (n <= free);
   assign drop  = !clear_i && (n > free);
   assign pop   = !clear_i && rvfi_valid_o && rvfi_ready_i;

   assign rvfi_valid_o = (count_o != '0);

   always_comb begin
      rvfi_lane_o = '0;
      if (rvfi_valid_o) begin
         rvfi_lane_o       = mem[rd_ptr];
         rvfi_lane_o.valid = 1'b1;
      end
   end

   // Resync to the last lane even on dropped cycles to avoid cascades.
   always_comb begin
      ord_bad = 1'b0;
      exp_nxt = exp_q;
      for (int k = 0; k < NRET; k++) begin
         if (valid_i[k]) begin
            if (lanes[k].order != exp_q + 64'(idx[k])) ord_bad = 1'b1;
            exp_nxt = lanes[k].order + 64'd1;
         end
      end
   end

   assign drop_sum = {1'b0, drop_cnt_o} + 33'(n);

   always_ff @(posedge clk_i) begin
      for (int k = 0; k < NRET; k++) begin
         if (push && valid_i[k])
            mem[wr_ptr + AW'(idx[k])] <= lanes[k];
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         count_o     <= '0;
         overflow_o  <= 1'b0;
         order_err_o <= 1'b0;
         drop_cnt_o  <= '0;
         exp_q       <= ORDER_INIT;
      end else if (clear_i) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         count_o     <= '0;
         overflow_o  <= 1'b0;
         order_err_o <= 1'b0;
         drop_cnt_o  <= '0;
         exp_q       <= ORDER_INIT;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(n);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         count_o <= count_o + (push ? n : '0) - (pop ? CW'(1) : '0);
         if (drop) begin
            overflow_o <= 1'b1;
            drop_cnt_o <= drop_sum[32] ? '1 : drop_sum[31:0];
         end
         if (ord_bad) order_err_o <= 1'b1;
         exp_q <= exp_nxt;
      end
   end

endmodule

// File: tb/tb_rvfi_wrap_fifo.sv
// Directed vector bench for rvfi_wrap_fifo (NRET=2, DEPTH=8).
// Each vector holds inputs for a cycle and the state expected at its start.
module tb_rvfi_wrap_fifo;
   import ariane_rvfi_pkg::*;

   localparam int unsigned DEPTH = 8;
   localparam int unsigned CW    = $clog2(DEPTH+1);

   logic                   clk_i = 1'b0;
   logic                   rst_i;
   logic                   clear_i;
   logic [NRET-1:0]        valid_i, trap_i, halt_i, intr_i;
   logic [NRET*64-1:0]     order_i;
   logic [NRET*ILEN-1:0]   insn_i;
   logic [NRET*XLEN-1:0]   cause_i, rs1_rdata_i, rs2_rdata_i, rd_wdata_i;
   logic [NRET*XLEN-1:0]   pc_rdata_i, pc_wdata_i, mem_addr_i;
   logic [NRET*2-1:0]      mode_i, ixl_i;
   logic [NRET*5-1:0]      rs1_addr_i, rs2_addr_i, rd_addr_i;
   logic [NRET*XB-1:0]     mem_rmask_i, mem_wmask_i;
   logic [NRET*XLEN-1:0]   mem_rdata_i, mem_wdata_i;
   logic                   rvfi_valid_o;
   logic                   rvfi_ready_i;
   rvfi_lane_t             rvfi_lane_o;
   logic [CW-1:0]          count_o;
   logic                   overflow_o;
   logic                   order_err_o;
   logic [31:0]            drop_cnt_o;

   int tests = 0;
   int fails = 0;

   always #5 clk_i = ~clk_i;

   rvfi_wrap_fifo #(.DEPTH(DEPTH), .ORDER_INIT(64'd0)) dut (
      .clk_i, .rst_i, .clear_i, .valid_i, .trap_i, .halt_i, .intr_i,
      .order_i, .insn_i, .cause_i, .rs1_rdata_i, .rs2_rdata_i,
      .rd_wdata_i, .pc_rdata_i, .pc_wdata_i, .mem_addr_i, .mode_i,
      .ixl_i, .rs1_addr_i, .rs2_addr_i, .rd_addr_i, .mem_rmask_i,
      .mem_wmask_i, .mem_rdata_i, .mem_wdata_i, .rvfi_valid_o,
      .rvfi_ready_i, .rvfi_lane_o, .count_o, .overflow_o,
      .order_err_o, .drop_cnt_o
   );

   typedef struct {
      logic        clr;
      logic [1:0]  v;
      logic [63:0] o0;
      logic [63:0] o1;
      logic        rdy;
      logic        e_val;
      logic [63:0] e_ord;
      int          e_cnt;
      logic        e_ovf;
      logic        e_err;
      int          e_drop;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(logic clr, logic [1:0] v, logic [63:0] o0,
                               logic [63:0] o1, logic rdy, logic ev,
                               logic [63:0] eo, int ec, logic eovf,
                               logic eerr, int ed);
      vec_t t;
      t.clr = clr; t.v = v; t.o0 = o0; t.o1 = o1; t.rdy = rdy;
      t.e_val = ev; t.e_ord = eo; t.e_cnt = ec;
      t.e_ovf = eovf; t.e_err = eerr; t.e_drop = ed;
      return t;
   endfunction

   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic drive(logic clr, logic [1:0] v, logic [63:0] o0,
                        logic [63:0] o1, logic rdy);
      logic [63:0] o [2];
      o[0] = o0;
      o[1] = o1;
      clear_i      = clr;
      valid_i      = v;
      rvfi_ready_i = rdy;
      for (int k = 0; k < 2; k++) begin
         order_i[k*64 +: 64]       = o[k];
         insn_i[k*ILEN +: ILEN]    = 32'h0A00_0000 ^ o[k][31:0];
         pc_rdata_i[k*XLEN +: XLEN] = o[k] << 2;
      end
   endtask

   task automatic check_state(string tag, logic ev, logic [63:0] eo,
                              int ec, logic eovf, logic eerr, int ed);
      chk({tag, " valid"}, 64'(rvfi_valid_o), 64'(ev));
      chk({tag, " count"}, 64'(count_o), 64'(ec));
      chk({tag, " overflow"}, 64'(overflow_o), 64'(eovf));
      chk({tag, " order_err"}, 64'(order_err_o), 64'(eerr));
      chk({tag, " drop_cnt"}, 64'(drop_cnt_o), 64'(ed));
      if (ev) begin
         chk({tag, " order"}, rvfi_lane_o.order, eo);
         chk({tag, " insn"}, 64'(rvfi_lane_o.insn),
             64'(32'h0A00_0000 ^ eo[31:0]));
         chk({tag, " pc"}, rvfi_lane_o.pc_rdata, eo << 2);
         chk({tag, " lane.valid"}, 64'(rvfi_lane_o.valid), 64'd1);
      end else begin
         chk({tag, " lane_zero"}, 64'(rvfi_lane_o != '0), 64'd0);
      end
   endtask

   initial begin
      rst_i = 1'b1;
      trap_i = '0; halt_i = '0; intr_i = '0;
      cause_i = '0; rs1_rdata_i = '0; rs2_rdata_i = '0; rd_wdata_i = '0;
      pc_wdata_i = '0; mem_addr_i = '0; mode_i = '0; ixl_i = '0;
      rs1_addr_i = '0; rs2_addr_i = '0; rd_addr_i = '0;
      mem_rmask_i = '0; mem_wmask_i = '0;
      mem_rdata_i = '0; mem_wdata_i = '0;
      drive(1'b0, 2'b00, 64'd0, 64'd0, 1'b0);

      //            clr v      o0  o1  rdy ev eo  cnt ovf err drop
      // dual-lane push, streamed out on consecutive cycles
      vecs.push_back(mk(0, 2'b11,  0,  1, 1, 0,  0, 0, 0, 0, 0));
      vecs.push_back(mk(0, 2'b00,  0,  0, 1, 1,  0, 2, 0, 0, 0));
      vecs.push_back(mk(0, 2'b00,  0,  0, 1, 1,  1, 1, 0, 0, 0));
      vecs.push_back(mk(1, 2'b00,  0,  0, 1, 0,  0, 0, 0, 0, 0));
      // lane1 only; lane0 garbage ignored
      vecs.push_back(mk(0, 2'b10, 55,  0, 1, 0,  0, 0, 0, 0, 0));
      vecs.push_back(mk(0, 2'b00,  0,  0, 1, 1,  0, 1, 0, 0, 0));
      vecs.push_back(mk(1, 2'b00,  0,  0, 1, 0,  0, 0, 0, 0, 0));
      // fill to 8 with ready=0, then a dropped cycle
      vecs.push_back(mk(0, 2'b11,  0,  1, 0, 0,  0, 0, 0, 0, 0));
      vecs.push_back(mk(0, 2'b11,  2,  3, 0, 1,  0, 2, 0, 0, 0));
      vecs.push_back(mk(0, 2'b11,  4,  5, 0, 1,  0, 4, 0, 0, 0));
      vecs.push_back(mk(0, 2'b11,  6,  7, 0, 1,  0, 6, 0, 0, 0));
      vecs.push_back(mk(0, 2'b11,  8,  9, 0, 1,  0, 8, 0, 0, 0));
      // full + pop + push 1: dropped; next cycle count 7 accepts
      vecs.push_back(mk(0, 2'b01, 10,  0, 1, 1,  0, 8, 1, 0, 2));
      vecs.push_back(mk(0, 2'b01, 11,  0, 0, 1,  1, 7, 1, 0, 3));
      vecs.push_back(mk(0, 2'b00,  0,  0, 1, 1,  1, 8, 1, 0, 3));
      vecs.push_back(mk(0, 2'b00,  0,  0, 1, 1,  2, 7, 1, 0, 3));
      vecs.push_back(mk(0, 2'b00,  0,  0, 1, 1,  3, 6, 1, 0, 3));
      vecs.push_back(mk(0, 2'b00,  0,  0, 1, 1,  4, 5, 1, 0, 3));
      vecs.push_back(mk(0, 2'b00,  0,  0, 1, 1,  5, 4, 1, 0, 3));
      vecs.push_back(mk(0, 2'b00,  0,  0, 1, 1,  6, 3, 1, 0, 3));
      vecs.push_back(mk(0, 2'b00,  0,  0, 1, 1,  7, 2, 1, 0, 3));
      vecs.push_back(mk(0, 2'b00,  0,  0, 1, 1, 11, 1, 1, 0, 3));
      vecs.push_back(mk(1, 2'b00,  0,  0, 1, 0,  0, 0, 1, 0, 3));
      // order gap 1 -> 3, then continuing stream raises nothing new
      vecs.push_back(mk(0, 2'b11,  0,  1, 1, 0,  0, 0, 0, 0, 0));
      vecs.push_back(mk(0, 2'b11,  3,  4, 1, 1,  0, 2, 0, 0, 0));
      vecs.push_back(mk(0, 2'b11,  5,  6, 1, 1,  1, 3, 0, 1, 0));
      vecs.push_back(mk(0, 2'b01,  7,  0, 1, 1,  3, 4, 0, 1, 0));
      vecs.push_back(mk(0, 2'b00,  0,  0, 1, 1,  4, 4, 0, 1, 0));
      vecs.push_back(mk(0, 2'b00,  0,  0, 1, 1,  5, 3, 0, 1, 0));
      vecs.push_back(mk(0, 2'b00,  0,  0, 1, 1,  6, 2, 0, 1, 0));
      vecs.push_back(mk(0, 2'b00,  0,  0, 1, 1,  7, 1, 0, 1, 0));
      vecs.push_back(mk(0, 2'b00,  0,  0, 1, 0,  0, 0, 0, 1, 0));
      // clear with 6 queued and a concurrent push
      vecs.push_back(mk(1, 2'b00,  0,  0, 0, 0,  0, 0, 0, 1, 0));
      vecs.push_back(mk(0, 2'b11,  0,  1, 0, 0,  0, 0, 0, 0, 0));
      vecs.push_back(mk(0, 2'b11,  2,  3, 0, 1,  0, 2, 0, 0, 0));
      vecs.push_back(mk(0, 2'b11,  4,  5, 0, 1,  0, 4, 0, 0, 0));
      vecs.push_back(mk(1, 2'b11,  6,  7, 1, 1,  0, 6, 0, 0, 0));
      vecs.push_back(mk(0, 2'b11,  0,  1, 1, 0,  0, 0, 0, 0, 0));
      vecs.push_back(mk(0, 2'b00,  0,  0, 1, 1,  0, 2, 0, 0, 0));
      vecs.push_back(mk(0, 2'b00,  0,  0, 1, 1,  1, 1, 0, 0, 0));
      vecs.push_back(mk(0, 2'b00,  0,  0, 1, 0,  0, 0, 0, 0, 0));

      repeat (2) @(negedge clk_i);
      rst_i = 1'b0;

      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge clk_i);
         drive(vecs[i].clr, vecs[i].v, vecs[i].o0, vecs[i].o1, vecs[i].rdy);
         check_state($sformatf("v%0d", i), vecs[i].e_val, vecs[i].e_ord,
                     vecs[i].e_cnt, vecs[i].e_ovf, vecs[i].e_err,
                     vecs[i].e_drop);
      end

      // reset mid-stream: queued entries vanish without a clock edge
      @(negedge clk_i);
      drive(1'b0, 2'b11, 64'd2, 64'd3, 1'b0);
      @(negedge clk_i);
      drive(1'b0, 2'b00, 64'd0, 64'd0, 1'b0);
      check_state("pre_rst", 1'b1, 64'd2, 2, 1'b0, 1'b0, 0);
      #2 rst_i = 1'b1;
      #1 check_state("async_rst", 1'b0, 64'd0, 0, 1'b0, 1'b0, 0);
      @(negedge clk_i);
      rst_i = 1'b0;
      drive(1'b0, 2'b11, 64'd0, 64'd1, 1'b1);
      @(negedge clk_i);
      drive(1'b0, 2'b00, 64'd0, 64'd0, 1'b1);
      check_state("post_rst", 1'b1, 64'd0, 2, 1'b0, 1'b0, 0);
      @(negedge clk_i);
      check_state("post_rst2", 1'b1, 64'd1, 1, 1'b0, 1'b0, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
